// File: rtl/nvram_upload.sv
// Serves HPS ioctl upload byte reads from work RAM and requests an upload once core writes go quiet.
// Latency: in-range read stalls RD_LAT+1 clocks, out-of-range read 1 clock; every output is registered.
// Backpressure: ioctl_wait holds the HPS; `define NVRAM_UPLOAD_REQ_EN compiles in the dirty/quiet tracker.

module nvram_upload #(
    parameter int          AW           = 10,
    parameter int          RD_LAT       = 2,
    parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
    parameter logic [23:0] QUIET_CYCLES = 24'd1_100_000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          ioctl_upload_req,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    input  logic          core_wr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAITQ
    } state_t;

    localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);
    localparam logic [24:0] ADDR_LIM = 25'(2 ** AW);

    state_t          state, state_nx;
    logic [1:0]      lat_cnt, lat_cnt_nx;
    logic            oor_pend, oor_nx;
    logic [7:0]      din_nx;
    logic            wait_nx;
    logic            rd_nx;
    logic [AW-1:0]   addr_nx;
    logic            sel;
    logic            in_range;

    assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_range = ioctl_addr < ADDR_LIM;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lat_cnt    <= 2'd0;
            oor_pend   <= 1'b0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
        end else begin
            state      <= state_nx;
            lat_cnt    <= lat_cnt_nx;
            oor_pend   <= oor_nx;
            ioctl_din  <= din_nx;
            ioctl_wait <= wait_nx;
            ram_rd     <= rd_nx;
            ram_addr   <= addr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        oor_nx     = 1'b0;
        din_nx     = ioctl_din;
        wait_nx    = ioctl_wait;
        rd_nx      = 1'b0;
        addr_nx    = ram_addr;
        case (state)
            S_IDLE: begin
                // Out-of-range reads hold wait for one cycle, then return FF.
                if (oor_pend) begin
                    din_nx  = 8'hFF;
                    wait_nx = 1'b0;
                end else if (ioctl_rd && sel) begin
                    wait_nx = 1'b1;
                    if (in_range) begin
                        state_nx = S_ISSUE;
                        addr_nx  = ioctl_addr[AW-1:0];
                        rd_nx    = 1'b1;
                    end else begin
                        oor_nx = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!sel) begin
                    state_nx = S_IDLE;
                    wait_nx  = 1'b0;
                end else begin
                    state_nx   = S_WAITQ;
                    lat_cnt_nx = LAT_INIT;
                end
            end
            S_WAITQ: begin
                if (!sel) begin
                    state_nx = S_IDLE;
                    wait_nx  = 1'b0;
                end else if (lat_cnt == 2'd0) begin
                    state_nx = S_IDLE;
                    din_nx   = ram_q;
                    wait_nx  = 1'b0;
                end else begin
                    lat_cnt_nx = lat_cnt - 2'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                wait_nx  = 1'b0;
            end
        endcase
    end

`ifdef NVRAM_UPLOAD_REQ_EN
    logic        sel_q;
    logic        dirty, dirty_nx;
    logic [23:0] quiet_cnt, quiet_cnt_nx;
    logic        req_nx;

    // Any upload session holds the quiet counter at zero, so quiet time is
    // measured from the later of the last core write and the session end.
    always_comb begin
        quiet_cnt_nx = quiet_cnt;
        if (core_wr || ioctl_upload) begin
            quiet_cnt_nx = 24'd0;
        end else if (dirty && (quiet_cnt != QUIET_CYCLES)) begin
            quiet_cnt_nx = quiet_cnt + 24'd1;
        end
        req_nx   = dirty && !core_wr && !ioctl_upload && (quiet_cnt_nx == QUIET_CYCLES);
        dirty_nx = dirty;
        if (core_wr) begin
            dirty_nx = 1'b1;
        end else if (sel && !sel_q) begin
            dirty_nx = 1'b0;
        end else if (req_nx) begin
            dirty_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_q            <= 1'b0;
            dirty            <= 1'b0;
            quiet_cnt        <= 24'd0;
            ioctl_upload_req <= 1'b0;
        end else begin
            sel_q            <= sel;
            dirty            <= dirty_nx;
            quiet_cnt        <= quiet_cnt_nx;
            ioctl_upload_req <= req_nx;
        end
    end
`else
    logic unused_core_wr;
    assign unused_core_wr   = core_wr;
    assign ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_upload.sv
// Randomized self-checking bench for nvram_upload: fetch timing/abort/reset and the quiet-time upload request.
module tb_nvram_upload;

    localparam int         AW     = 10;
    localparam int         RD_LAT = 2;
    localparam logic [7:0] IDX    = 8'd4;
    localparam int         Q      = 16;
`ifdef NVRAM_UPLOAD_REQ_EN
    localparam bit REQ_EN = 1'b1;
`else
    localparam bit REQ_EN = 1'b0;
`endif

    logic          clk_sys;
    logic          reset_n;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          ioctl_upload_req;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_q;
    logic          core_wr;

    nvram_upload #(
        .AW(AW), .RD_LAT(RD_LAT), .UPLOAD_INDEX(IDX), .QUIET_CYCLES(24'(Q))
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ioctl_upload_req(ioctl_upload_req),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q), .core_wr(core_wr)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // RAM with RD_LAT pipeline stages; returns inverted data when not strobed.
    logic [7:0] mem  [1024];
    logic [7:0] pipe [RD_LAT];
    always @(posedge clk_sys) begin
        pipe[0] <= ram_rd ? mem[ram_addr] : ~mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[RD_LAT-1];

    int errors;
    int checks;

    // Request model: a request fires Q+1 cycles after the latest write/upload-active cycle while dirty.
    bit m_dirty, m_sel_q, m_req;
    int m_cyc, m_last;

    task automatic tick();
        logic s, d;
        s = ioctl_upload && (ioctl_index == IDX);
        if (!reset_n) begin
            m_dirty = 1'b0; m_sel_q = 1'b0; m_req = 1'b0; m_last = -1000;
        end else begin
            d = m_dirty;
            if (core_wr || ioctl_upload) m_last = m_cyc;
            if (core_wr) d = 1'b1;
            else if (s && !m_sel_q) d = 1'b0;
            m_req = REQ_EN && d && !core_wr && !ioctl_upload && ((m_cyc - m_last) == Q);
            if (m_req) d = 1'b0;
            m_dirty = d;
            m_sel_q = s;
        end
        m_cyc++;
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
        ioctl_addr = 25'd0; core_wr = 1'b0;
        repeat (3) tick();
        checks++; if (ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h exp 00", ioctl_din); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b exp 0", ioctl_wait); end
        checks++; if (ioctl_upload_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", ioctl_upload_req); end
        checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd: got %b exp 0", ram_rd); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %h exp 0", ram_addr); end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++; if (ioctl_wait !== 1'b0 || ram_rd !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got wait=%b rd=%b exp 0 0", ioctl_wait, ram_rd);
        end
    endtask

    // Strobe at the current negedge (cycle 0); returns at the negedge of the cycle with the new data.
    task automatic do_read(input logic [24:0] a);
        logic       inr, exp_rd, exp_wait;
        logic [7:0] prior, exp_dat;
        int         n;
        inr     = a < 25'd1024;
        prior   = ioctl_din;
        exp_dat = inr ? mem[a[AW-1:0]] : 8'hFF;
        n       = inr ? RD_LAT + 2 : 2;
        ioctl_rd = 1'b1; ioctl_addr = a;
        for (int k = 1; k <= n; k++) begin
            tick();
            ioctl_rd = 1'b0;
            exp_rd   = inr && (k == 1);
            exp_wait = inr ? (k <= RD_LAT + 1) : (k == 1);
            checks++; if (ram_rd !== exp_rd) begin
                errors++; $display("FAIL rd_ram_rd a=%h k=%0d: got %b exp %b", a, k, ram_rd, exp_rd);
            end
            checks++; if (ioctl_wait !== exp_wait) begin
                errors++; $display("FAIL rd_wait a=%h k=%0d: got %b exp %b", a, k, ioctl_wait, exp_wait);
            end
            if (exp_rd) begin
                checks++; if (ram_addr !== a[AW-1:0]) begin
                    errors++; $display("FAIL rd_ram_addr: got %h exp %h", ram_addr, a[AW-1:0]);
                end
            end
            if (k == n) begin
                checks++; if (ioctl_din !== exp_dat) begin
                    errors++; $display("FAIL rd_data a=%h: got %h exp %h", a, ioctl_din, exp_dat);
                end
            end else if (inr) begin
                checks++; if (ioctl_din !== prior) begin
                    errors++; $display("FAIL rd_din_early a=%h k=%0d: got %h exp %h", a, k, ioctl_din, prior);
                end
            end
        end
    endtask

    task automatic test_fetch();
        ioctl_upload = 1'b1; ioctl_index = IDX;
        tick();
        mem[5] = 8'h5A;
        do_read(25'd5);
        for (int i = 0; i < 6; i++) begin
            tick();
            do_read(25'($urandom_range(0, 1023)));
        end
        tick();
    endtask

    task automatic test_out_of_range();
        do_read(25'h400);
        tick();
        for (int i = 0; i < 3; i++) begin
            do_read(25'($urandom_range(1024, 32'h1FF_FFFF)));
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) do_read(25'($urandom_range(1024, 4096)));
            else do_read(25'($urandom_range(0, 1023)));
        end
        tick();
    endtask

    task automatic test_ignored();
        logic [7:0] prior;
        logic [9:0] a, b;
        prior = ioctl_din;
        ioctl_index = 8'd0; ioctl_rd = 1'b1; ioctl_addr = 25'($urandom_range(0, 1023));
        tick();
        ioctl_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (ram_rd !== 1'b0 || ioctl_wait !== 1'b0 || ioctl_din !== prior) begin
                errors++; $display("FAIL ign_index k=%0d: got rd=%b wait=%b din=%h exp 0 0 %h",
                                   k, ram_rd, ioctl_wait, ioctl_din, prior);
            end
            tick();
        end
        ioctl_index = IDX;
        tick();
        a = 10'($urandom_range(0, 511)); b = 10'($urandom_range(512, 1023));
        mem[b] = ~mem[a];
        ioctl_rd = 1'b1; ioctl_addr = 25'(a);
        for (int k = 1; k <= RD_LAT + 4; k++) begin
            tick();
            ioctl_rd   = (k == 2);
            ioctl_addr = (k == 2) ? 25'(b) : 25'(a);
            checks++; if (ram_rd !== (k == 1) || ioctl_wait !== (k <= RD_LAT + 1)) begin
                errors++; $display("FAIL ign_busy k=%0d: got rd=%b wait=%b exp %b %b",
                                   k, ram_rd, ioctl_wait, k == 1, k <= RD_LAT + 1);
            end
            if (k >= RD_LAT + 2) begin
                checks++; if (ioctl_din !== mem[a]) begin
                    errors++; $display("FAIL ign_busy_data k=%0d: got %h exp %h", k, ioctl_din, mem[a]);
                end
            end
        end
        ioctl_rd = 1'b0;
    endtask

    task automatic test_abort();
        logic [9:0] a, b;
        logic [7:0] prior;
        a = 10'($urandom_range(0, 511)); b = 10'($urandom_range(512, 1023));
        mem[b] = ~mem[a];
        do_read(25'(a));
        prior = ioctl_din;
        ioctl_rd = 1'b1; ioctl_addr = 25'(b);
        tick();
        ioctl_rd = 1'b0;
        tick();
        ioctl_upload = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            tick();
            checks++; if (ioctl_wait !== 1'b0 || ioctl_din !== prior) begin
                errors++; $display("FAIL abort k=%0d: got wait=%b din=%h exp 0 %h", k, ioctl_wait, ioctl_din, prior);
            end
        end
        ioctl_upload = 1'b1;
        tick();
        do_read(25'(b));
        tick();
    endtask

    task automatic test_reset_mid();
        logic [9:0] a, b;
        a = 10'($urandom_range(0, 511)); b = 10'($urandom_range(512, 1023));
        mem[a] = 8'hA5;
        do_read(25'(a));
        ioctl_rd = 1'b1; ioctl_addr = 25'(b);
        tick();
        ioctl_rd = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ioctl_din !== 8'h00 || ioctl_wait !== 1'b0 || ram_rd !== 1'b0 ||
                      ram_addr !== '0 || ioctl_upload_req !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got din=%h wait=%b rd=%b addr=%h req=%b exp all 0",
                               ioctl_din, ioctl_wait, ram_rd, ram_addr, ioctl_upload_req);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // One dirty-tracker scenario; lo=-1 means no request is expected.
    task automatic test_dirty(input string name, input int wr_a, input int wr_b, input int s_start,
                              input int s_len, input logic [7:0] s_idx, input int lo, input int hi, input int n);
        int  cnt, first, exp_cnt;
        bit  pos_ok;
        cnt = 0; first = -1;
        for (int k = 0; k < n; k++) begin
            core_wr      = (k == wr_a) || (k == wr_b);
            ioctl_upload = (k >= s_start) && (k < s_start + s_len);
            ioctl_index  = ioctl_upload ? s_idx : IDX;
            checks++; if (ioctl_upload_req !== m_req) begin
                errors++; $display("FAIL %s_req k=%0d: got %b exp %b", name, k, ioctl_upload_req, m_req);
            end
            if (ioctl_upload_req === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            tick();
        end
        core_wr = 1'b0; ioctl_upload = 1'b0;
        exp_cnt = (REQ_EN && lo >= 0) ? 1 : 0;
        checks++; if (cnt !== exp_cnt) begin
            errors++; $display("FAIL %s_count: got %0d exp %0d", name, cnt, exp_cnt);
        end
        pos_ok = (exp_cnt == 1) ? (first >= lo && first <= hi) : (first == -1);
        checks++; if (!pos_ok) begin
            errors++; $display("FAIL %s_pos: got %0d exp %0d..%0d", name, first, lo, hi);
        end
    endtask

    task automatic test_random_dirty();
        ioctl_upload = 1'b0; ioctl_index = IDX;
        for (int k = 0; k < 800; k++) begin
            core_wr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) begin
                ioctl_upload = ~ioctl_upload;
                ioctl_index  = ($urandom_range(0, 1) == 0) ? IDX : 8'd7;
            end
            checks++; if (ioctl_upload_req !== m_req) begin
                errors++; $display("FAIL rand_req k=%0d: got %b exp %b", k, ioctl_upload_req, m_req);
            end
            tick();
        end
        core_wr = 1'b0; ioctl_upload = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        m_dirty = 1'b0; m_sel_q = 1'b0; m_req = 1'b0; m_cyc = 0; m_last = -1000;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        test_reset();
        test_fetch();
        test_out_of_range();
        test_back_to_back();
        test_ignored();
        test_abort();
        test_reset_mid();
        test_dirty("single_wr",   0,  -1, 1000, 0,  IDX,  16, 17, 40);
        test_dirty("rewrite",     0,   8, 1000, 0,  IDX,  24, 25, 45);
        test_dirty("wr_in_sess",  5,  -1,    2, 20, IDX,  38, 39, 60);
        test_dirty("sel_clears",  0,  -1,    5, 10, IDX,  -1, -1, 50);
        test_dirty("other_index", 0,  -1,    5, 10, 8'd0, 31, 32, 50);
        test_dirty("wr_at_rise",  5,  -1,    5, 10, IDX,  31, 32, 50);
        test_random_dirty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
